// File: rtl/rom_seq_pkg.sv
// Shared types and the fixed ROM contents for the sequential ROM burst reader.
package rom_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_e;

    localparam int ROM_TABLE_LEN = 16;

    // The default table repeats every 16 words so deeper ROMs stay populated.
    function automatic logic [31:0] rom_word(input int index);
        logic [3:0] w;
        case (index % ROM_TABLE_LEN)
            0:       w = 4'h2;
            1:       w = 4'h2;
            2:       w = 4'hE;
            3:       w = 4'h2;
            4:       w = 4'h4;
            5:       w = 4'hA;
            6:       w = 4'hC;
            7:       w = 4'h0;
            8:       w = 4'hA;
            9:       w = 4'h2;
            10:      w = 4'hE;
            11:      w = 4'h2;
            12:      w = 4'h4;
            13:      w = 4'hA;
            14:      w = 4'hC;
            15:      w = 4'h0;
            default: w = 4'h0;
        endcase
        return {28'd0, w};
    endfunction

endpackage

// File: rtl/rom_table.sv
// Combinational ROM lookup; contents are constants folded in at elaboration.
module rom_table
    import rom_seq_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 16
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // Unpopulated addresses read as zero; the sequencer never drives them.
    always_comb begin
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i)) begin
                data = DATA_W'(rom_word(i));
            end
        end
    end

endmodule

// File: rtl/rom_seq_reader.sv
// Streams a burst of consecutive ROM words, wrapping at DEPTH, with ready/valid output.
module rom_seq_reader
    import rom_seq_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              err,
    output logic              busy
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DepthL   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0] raddr_d;
    logic [LEN_W-1:0]  remaining_q;
    logic              err_q;

    logic reqFire;
    logic reqLegal;
    logic xferFire;
    logic lastWord;

    assign reqFire  = req_valid && req_ready;
    assign reqLegal = (req_len != '0) && ({1'b0, req_addr} < DepthL);
    assign xferFire = out_valid && out_ready;
    assign lastWord = (remaining_q == LEN_W'(1));
    assign raddr_d  = (raddr_q == LastAddr) ? '0 : raddr_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            raddr_q     <= '0;
            remaining_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (reqFire) begin
                        if (reqLegal) begin
                            state_q     <= READ;
                            raddr_q     <= req_addr;
                            remaining_q <= req_len;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (xferFire) begin
                        raddr_q     <= raddr_d;
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (lastWord) begin
                            state_q <= IDLE;
                        end
                    end
                    // Abort wins over a mid-burst transfer; a coinciding last word still completes.
                    if (abort) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == READ);
    assign out_addr  = raddr_q;
    assign out_last  = out_valid && lastWord;
    assign err       = err_q;

    rom_table #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_rom_table (
        .addr(raddr_q),
        .data(out_data)
    );

endmodule

// File: tb/tb_rom_seq_reader.sv
// Directed plus randomized bursts checked against a per-word expectation built from the ROM table.
module tb_rom_seq_reader;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 16;
    localparam int LEN_W  = 6;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              err;
    logic              busy;

    int testCount = 0;
    int failCount = 0;

    logic [DATA_W-1:0] romModel [16] = '{4'h2, 4'h2, 4'hE, 4'h2, 4'h4, 4'hA, 4'hC, 4'h0,
                                         4'hA, 4'h2, 4'hE, 4'h2, 4'h4, 4'hA, 4'hC, 4'h0};

    rom_seq_reader #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_len  (req_len),
        .abort    (abort),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_addr (out_addr),
        .out_last (out_last),
        .err      (err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " out_valid"}, 32'(out_valid), 0);
        checkOutput({tag, " busy"},      32'(busy),      0);
        checkOutput({tag, " req_ready"}, 32'(req_ready), 1);
        checkOutput({tag, " err"},       32'(err),       0);
    endtask

    // Expected word k of a burst is simply ROM[(start + k) mod DEPTH].
    task automatic applyStimulus(input int addr, input int len, input int stallFirst,
                                 input int readyPct, input int abortAt, input bit abortOnReq);
        int k;
        int cycles;
        int ea;
        checkOutput("req_ready before req", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_addr  = ADDR_W'(addr);
        req_len   = LEN_W'(len);
        abort     = abortOnReq;
        step();
        req_valid = 1'b0;
        abort     = 1'b0;
        checkOutput("err on accept", 32'(err), 0);
        k = 0;
        cycles = 0;
        while (k < len && cycles < len * 20 + 50) begin
            ea = (addr + k) % DEPTH;
            checkOutput("out_valid",      32'(out_valid), 1);
            checkOutput("busy",           32'(busy),      1);
            checkOutput("req_ready busy", 32'(req_ready), 0);
            checkOutput("out_addr",       32'(out_addr),  32'(ea));
            checkOutput("out_data",       32'(out_data),  32'(romModel[ea]));
            checkOutput("out_last",       32'(out_last),  32'(k == len - 1));
            out_ready = (cycles >= stallFirst) && ($urandom_range(99) < readyPct);
            if (k == abortAt) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                out_ready = 1'b0;
                checkIdle("after abort");
                return;
            end
            step();
            if (out_ready) k++;
            cycles++;
        end
        out_ready = 1'b0;
        if (k < len) checkOutput("burst timeout", 0, 1);
        checkIdle("burst end");
    endtask

    task automatic applyReject(input int addr, input int len);
        checkOutput("req_ready before reject", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_addr  = ADDR_W'(addr);
        req_len   = LEN_W'(len);
        step();
        req_valid = 1'b0;
        checkOutput("reject err pulse", 32'(err),       1);
        checkOutput("reject req_ready", 32'(req_ready), 1);
        checkOutput("reject out_valid", 32'(out_valid), 0);
        checkOutput("reject busy",      32'(busy),      0);
        step();
        checkOutput("reject err clear", 32'(err),       0);
        checkOutput("reject out_valid2", 32'(out_valid), 0);
    endtask

    initial begin
        int r;
        int a;
        int l;
        int ab;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        checkIdle("reset");
        checkOutput("reset out_addr", 32'(out_addr), 0);
        checkOutput("reset out_data", 32'(out_data), 32'h2);
        checkOutput("reset out_last", 32'(out_last), 0);
        rst_n = 1'b1;
        step();

        applyStimulus(2, 3, 0, 100, -1, 1'b0);
        applyStimulus(14, 4, 0, 100, -1, 1'b0);
        applyStimulus(5, 2, 3, 100, -1, 1'b0);
        applyReject(3, 0);
        applyReject(20, 4);
        applyStimulus(0, 8, 0, 100, 2, 1'b0);
        applyStimulus(7, 3, 0, 100, 2, 1'b0);
        applyStimulus(9, 2, 0, 100, -1, 1'b1);
        applyStimulus(15, 1, 0, 100, -1, 1'b0);
        applyStimulus(3, 40, 0, 100, -1, 1'b0);

        // Reset in the middle of a burst must drop it completely.
        req_valid = 1'b1;
        req_addr  = ADDR_W'(4);
        req_len   = LEN_W'(10);
        step();
        req_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        step();
        out_ready = 1'b0;
        checkIdle("mid-burst reset");
        checkOutput("mid-burst reset out_addr", 32'(out_addr), 0);
        checkOutput("mid-burst reset out_data", 32'(out_data), 32'h2);
        rst_n = 1'b1;
        step();
        checkIdle("after reset release");

        for (int n = 0; n < 30; n++) begin
            r = int'($urandom_range(9));
            if (r < 2) begin
                if (r == 0) applyReject(int'($urandom_range(15)), 0);
                else        applyReject(int'($urandom_range(31, 16)), int'($urandom_range(63, 1)));
            end else begin
                a  = int'($urandom_range(15));
                l  = int'($urandom_range(40, 1));
                ab = ($urandom_range(3) == 0) ? int'($urandom_range(l - 1)) : -1;
                applyStimulus(a, l, int'($urandom_range(2)), 60, ab, 1'($urandom_range(1)));
            end
            if ($urandom_range(1) == 1) step();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/rom_seq_reader.md
ROM_SEQ_READER -- requirements
Module: rom_seq_reader

Interface
REQ-001 Parameter DATA_W, default 4, ROM word width in bits.
REQ-002 Parameter ADDR_W, default 5, address width in bits.
REQ-003 Parameter DEPTH, default 16, number of populated words; legal range 1..2**ADDR_W.
REQ-004 Parameter LEN_W, default 6, burst-length field width.
REQ-005 Port clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port rst_n  input  1  synchronous, active-low reset.
REQ-007 Port req_valid  input  1  burst request present.
REQ-008 Port req_ready  output  1  block can accept a request.
REQ-009 Port req_addr  input  ADDR_W  burst start address.
REQ-010 Port req_len  input  LEN_W  burst length in words; 0 is illegal.
REQ-011 Port abort  input  1  single-cycle cancel of the active burst.
REQ-012 Port out_valid  output  1  out_data/out_addr/out_last valid.
REQ-013 Port out_ready  input  1  consumer accepts current word.
REQ-014 Port out_data  output  DATA_W  ROM word at out_addr.
REQ-015 Port out_addr  output  ADDR_W  registered read address.
REQ-016 Port out_last  output  1  current word is the final word of the burst.
REQ-017 Port err  output  1  one-cycle pulse on rejected request.
REQ-018 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-019 The block SHALL have states IDLE and READ only; req_ready = (state == IDLE).
REQ-020 A request is accepted on req_valid && req_ready with req_len != 0 and req_addr < DEPTH; the next cycle state = READ, raddr = req_addr, remaining = req_len, out_valid = 1.
REQ-021 A request with req_len == 0 or req_addr >= DEPTH SHALL be rejected: state stays IDLE, err = 1 for exactly the following cycle, no output word.
REQ-022 out_data SHALL be the combinational ROM lookup of the registered address raddr; out_addr = raddr (latency: acceptance cycle N -> first word valid in cycle N+1).
REQ-023 A word transfers on out_valid && out_ready; only then SHALL raddr advance and remaining decrement.
REQ-024 raddr SHALL wrap from DEPTH-1 to 0, never reaching addresses >= DEPTH.
REQ-025 out_last = out_valid && (remaining == 1); transfer of the last word returns state to IDLE with out_valid = 0 the next cycle.
REQ-026 While out_valid && !out_ready, out_data, out_addr, out_last SHALL remain stable.
REQ-027 abort in READ SHALL force IDLE, out_valid = 0 the next cycle regardless of out_ready; abort in IDLE SHALL be ignored.
REQ-028 abort coinciding with a last-word transfer: the transfer completes, state = IDLE; no err.
REQ-029 Bursts longer than DEPTH SHALL continue wrapping; remaining counts LEN_W bits without overflow.
REQ-030 ROM contents SHALL be fixed at elaboration: word i = rom_word(i) from the package; default table (hex) 2,2,E,2,4,A,C,0,A,2,E,2,4,A,C,0, truncated/zero-extended to DATA_W.

Reset
REQ-031 With rst_n = 0 at a clock edge: state = IDLE, raddr = 0, remaining = 0, out_valid = 0, err = 0, busy = 0; reset mid-burst SHALL discard the burst.
REQ-032 out_data during reset SHALL equal rom_word(0) (lookup of raddr = 0); consumers ignore it since out_valid = 0.

Structure
REQ-033 Package rom_seq_pkg SHALL hold the state enum and function rom_word(index) with the default table.
REQ-034 Sub-module rom_table (combinational, parameters DATA_W/ADDR_W/DEPTH, input addr, output data) SHALL implement the lookup.
REQ-035 Sequencer state, raddr, remaining and err SHALL be registers in rom_seq_reader.

Verification
REQ-036 Reset, then req addr=2 len=3, out_ready=1 -> words E,2,4 at addr 2,3,4 on consecutive cycles, out_last on third, busy falls after.
REQ-037 req addr=14 len=4 (DEPTH=16) -> addr 14,15,0,1, data C,0,2,2, out_last on addr 1.
REQ-038 req addr=5 len=2, out_ready low 3 cycles -> A held stable 3 cycles, then A,C transferred.
REQ-039 req len=0, then req addr=20 -> both rejected, err pulses one cycle each, req_ready stays 1.
REQ-040 req addr=0 len=8, abort after second transfer -> out_valid = 0 next cycle, req_ready = 1; rst_n low mid-burst -> same idle state.
